boolean_a: RTL and testbench
============================

Name: boolean_a

Overview:
- Clocked three-input Boolean function unit.
- Samples asynchronous inputs a, b, c through a synchronizer and qualifies them with a stability filter.
- Drives registered output d = f(a,b,c), where f is a parameterised 8-entry truth table.
- Used as a glitch-free, lab-level combinational-logic block whose output is safe to consume in the clk domain.

Parameters:
- TRUTH_TABLE, 8'hE2: bit index {a,b,c} gives f. The default implements d = (a & b) | (~b & c).
- SYNC_STAGES, 2: synchronizer flops per input. Legal range 1..4.
- STABLE_CYCLES, 2: consecutive cycles the synchronized input vector must hold before d may update. Legal range 1..15; 1 disables filtering.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  asynchronous operand, MSB of the index.
- b  input  1  asynchronous operand, middle bit of the index.
- c  input  1  asynchronous operand, LSB of the index.
- d  output  1  registered function result.

Behaviour:
- Reset (rst_n low, asynchronous assert, released synchronously by the system):
  - all synchronizer flops = 0
  - stored previous vector s_prev = 3'b000
  - stability counter cnt = 0
  - d = 0
- Synchronizer: the vector {a,b,c} passes through a SYNC_STAGES-deep flop chain. Its output is s[2:0].
- Stability counter, evaluated every rising edge:
  - if s != s_prev, then cnt <= 1
  - else cnt <= min(cnt+1, STABLE_CYCLES)
  - s_prev <= s
- Output update: on each edge where the next cnt value equals STABLE_CYCLES, d <= TRUTH_TABLE[s]. Otherwise d holds.
- With STABLE_CYCLES=1, d <= TRUTH_TABLE[s] every cycle.
- Latency: an input change settled before edge k appears on d after edge k + SYNC_STAGES + STABLE_CYCLES − 1. With the defaults this is 3 edges after the capturing edge (4 edges total including capture).
- Glitch rejection: an input vector held for fewer than STABLE_CYCLES synchronized cycles never reaches d.
- Simultaneous changes on several inputs are treated as one vector change. Skew between inputs shorter than one cycle is absorbed by the filter when STABLE_CYCLES ≥ 2.
- Counter saturates at STABLE_CYCLES. It does not wrap, so d keeps refreshing to the same value while the inputs are static.
- Reset mid-operation: all state clears immediately and d = 0. After release the pipeline refills from 3'b000.
- Default truth table, {a,b,c} -> d:
  - 000->0, 001->1, 010->0, 011->0
  - 100->0, 101->1, 110->1, 111->1
- No combinational path from any input to d.

Test Plan:
- Reset check: hold rst_n=0 with a=b=c=1 -> d=0. Assert rst_n=0 asynchronously mid-cycle while d=1 -> d falls to 0 immediately, without waiting for a clock edge.
- Exhaustive sweep with defaults: drive {a,b,c} = 000..111 in order, each held 10 clk cycles -> after the 4-edge latency d follows 0,1,0,0,0,1,1,1.
- Latency: from reset, change {a,b,c} 000->001 just before edge k -> d stays 0 through edge k+2 and becomes 1 after edge k+3.
- Glitch rejection: steady 000, pulse c=1 for exactly 1 cycle -> d remains 0. Pulse c=1 for 3 cycles -> d rises to 1 and returns to 0 after input returns plus latency.
- Parameter variant TRUTH_TABLE=8'h96 (3-input XOR), STABLE_CYCLES=1, SYNC_STAGES=1 -> sweep gives d = 0,1,1,0,1,0,0,1 with 2-edge latency.
- Reset mid-sweep: at vector 110 (d=1) assert rst_n for 1 cycle, then release with inputs held at 110 -> d=0 during reset, d=1 again 4 edges after release.

Source files
------------

// File: rtl/boolean_a.sv
// Glitch-filtered three-input truth-table unit: synchronize {a,b,c}, require a stable vector, register d = f(vector).
// Latency SYNC_STAGES + STABLE_CYCLES - 1 edges after capture; no backpressure, d is a plain registered level.
module boolean_a #(
  parameter logic [7:0] TRUTH_TABLE   = 8'hE2,
  parameter int         SYNC_STAGES   = 2,
  parameter int         STABLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] s;
  logic [2:0] s_prev;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
    end else begin
      sync_q[0] <= {a, b, c};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter saturates rather than wraps, so a static vector keeps refreshing d.
  always_comb begin
    cnt_next = 4'd1;
    if (s == s_prev) begin
      if (cnt >= STABLE) cnt_next = STABLE;
      else               cnt_next = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev <= 3'b000;
      cnt    <= 4'd0;
      d      <= 1'b0;
    end else begin
      s_prev <= s;
      cnt    <= cnt_next;
      if (cnt_next == STABLE) d <= TRUTH_TABLE[s];
    end
  end

endmodule

// File: tb/tb_boolean_a.sv
// Bench for boolean_a: default instance plus an XOR / no-filter variant, vector table, corner sequences and random vs. model.
module tb_boolean_a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic d0, d1;

  localparam logic [7:0] TT0 = 8'hE2;
  localparam logic [7:0] TT1 = 8'h96;

  always #5 clk = ~clk;

  boolean_a #(.TRUTH_TABLE(TT0), .SYNC_STAGES(2), .STABLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d0));
  boolean_a #(.TRUTH_TABLE(TT1), .SYNC_STAGES(1), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d1));

  // Reference model: list of vectors seen at each edge since reset; d updates when the
  // last STABLE synchronized vectors (delayed by SYNC edges, zeros before that) agree.
  logic [2:0] samp[$];
  logic mdl_d0, mdl_d1;

  function automatic logic [2:0] s_at(int j, int sync);
    if (j <= sync) return 3'b000;
    return samp[j-1-sync];
  endfunction

  function automatic logic upd(int m, int sync, int stable);
    if (m < stable) return 1'b0;
    for (int j = m - stable + 1; j < m; j++)
      if (s_at(j, sync) != s_at(m, sync)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      mdl_d0 <= 1'b0;
      mdl_d1 <= 1'b0;
    end else begin
      int m;
      samp.push_back({a, b, c});
      m = samp.size();
      if (upd(m, 2, 2)) mdl_d0 <= TT0[s_at(m, 2)];
      if (upd(m, 1, 1)) mdl_d1 <= TT1[s_at(m, 1)];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  typedef struct {
    logic [2:0] abc;
    logic       exp0;
    logic       exp1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'b000, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 1'b1, 1'b1};
    vecs[2] = '{3'b010, 1'b0, 1'b1};
    vecs[3] = '{3'b011, 1'b0, 1'b0};
    vecs[4] = '{3'b100, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 1'b1, 1'b0};
    vecs[6] = '{3'b110, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 1'b1, 1'b1};

    // Reset held with all inputs high
    drive(3'b111);
    repeat (3) @(negedge clk);
    check("reset_d0", d0, 1'b0);
    check("reset_d1", d1, 1'b0);

    drive(3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_d0", d0, 1'b0);

    // Latency: change lands before edge k; default visible after k+3, variant after k+1
    drive(3'b001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat_d0_e%0d", i), d0, (i == 3));
      check($sformatf("lat_d1_e%0d", i), d1, (i >= 1));
    end

    // Glitch rejection: one-cycle pulse must never appear on d0
    drive(3'b000);
    repeat (10) @(negedge clk);
    drive(3'b001);
    @(negedge clk);
    drive(3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("glitch1_d0_%0d", i), d0, 1'b0);
    end

    // Three-cycle pulse passes, then d returns to 0
    begin
      logic seen;
      seen = 1'b0;
      drive(3'b001);
      repeat (3) begin
        @(negedge clk);
        seen |= d0;
      end
      drive(3'b000);
      repeat (8) begin
        @(negedge clk);
        seen |= d0;
      end
      check("pulse3_rise", seen, 1'b1);
      check("pulse3_fall", d0, 1'b0);
    end

    // Exhaustive table sweep
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].abc);
      repeat (10) @(negedge clk);
      check($sformatf("sweep_d0_%0d", i), d0, vecs[i].exp0);
      check($sformatf("sweep_d1_%0d", i), d1, vecs[i].exp1);
    end

    // Mid-cycle async reset while d0=1 at vector 110
    drive(3'b110);
    repeat (10) @(negedge clk);
    check("pre_rst_d0", d0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d0", d0, 1'b0);
    @(negedge clk);
    check("in_rst_d0", d0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) check("rst_refill_d0_e2", d0, 1'b0);
      if (i == 4) check("rst_refill_d0_e4", d0, 1'b1);
    end

    // Randomized vectors with random hold lengths, checked every cycle against the model
    for (int it = 0; it < 400; it++) begin
      int hold;
      drive(3'($urandom_range(0, 7)));
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        @(negedge clk);
        check("rand_d0", d0, mdl_d0);
        check("rand_d1", d1, mdl_d1);
      end
      if (it == 200) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rand_rst_d0", d0, 1'b0);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
